// File: rtl/fetch_queue.sv
// Instruction fetch queue: pairs each issued PC with next-cycle imem data and
// buffers {pc, inst} in a circular FIFO presenting the two oldest entries.
module fetch_queue #(
  parameter int ADDR_WIDTH = 16,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     pc,
  input  logic [INST_WIDTH-1:0]     imem_data,
  input  logic                      flush,
  input  logic [1:0]                pop,
  output logic                      pc_stall,
  output logic                      out0_valid,
  output logic [ADDR_WIDTH-1:0]     out0_pc,
  output logic [INST_WIDTH-1:0]     out0_inst,
  output logic                      out1_valid,
  output logic [ADDR_WIDTH-1:0]     out1_pc,
  output logic [INST_WIDTH-1:0]     out1_inst,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  entry_t                mem [DEPTH];
  logic [PW-1:0]         head, tail, head1;
  logic [CW-1:0]         cnt;
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_pc;

  logic                  push;
  logic [1:0]            pop_c;
  logic [CW-1:0]         pop_eff;
  logic [CW:0]           occ;

  assign push    = req_valid && !flush;
  assign pop_c   = (pop == 2'd3) ? 2'd2 : pop;
  assign pop_eff = (CW'(pop_c) > cnt) ? cnt : CW'(pop_c);

  // Stall looks only at registers so decode's pop never reaches the PC combinationally.
  assign occ      = {1'b0, cnt} + (CW+1)'(req_valid);
  assign pc_stall = occ >= (CW+1)'(DEPTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      req_valid <= 1'b0;
      req_pc    <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      req_valid <= 1'b0;
    end else begin
      req_valid <= !pc_stall;
      if (!pc_stall) req_pc <= pc;
      if (push) tail <= tail + PW'(1);
      head <= head + pop_eff[PW-1:0];
      cnt  <= cnt + CW'(push) - pop_eff;
    end
  end

  // Storage is intentionally left uncleared by reset.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{pc: req_pc, inst: imem_data};
  end

  assign head1      = head + PW'(1);
  assign out0_valid = cnt >= CW'(1);
  assign out1_valid = cnt >= CW'(2);

  // Invalid slots read as zero so never-written storage cannot leak to decode.
  always_comb begin
    out0_pc   = '0;
    out0_inst = '0;
    out1_pc   = '0;
    out1_inst = '0;
    if (out0_valid) begin
      out0_pc   = mem[head].pc;
      out0_inst = mem[head].inst;
    end
    if (out1_valid) begin
      out1_pc   = mem[head1].pc;
      out1_inst = mem[head1].inst;
    end
  end

  assign count = cnt;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: the bench models the PC register and a
// 1-cycle instruction memory, and checks outputs against hand-derived values.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [31:0] imem_data;
  logic        flush;
  logic [1:0]  pop;
  logic        pc_stall;
  logic        out0_valid, out1_valid;
  logic [15:0] out0_pc, out1_pc;
  logic [31:0] out0_inst, out1_inst;
  logic [2:0]  count;
  logic [15:0] target;

  int n_vec = 0;
  int n_err = 0;

  fetch_queue #(.ADDR_WIDTH(16), .INST_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pc(pc), .imem_data(imem_data), .flush(flush),
    .pop(pop), .pc_stall(pc_stall),
    .out0_valid(out0_valid), .out0_pc(out0_pc), .out0_inst(out0_inst),
    .out1_valid(out1_valid), .out1_pc(out1_pc), .out1_inst(out1_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [15:0] a);
    return {a ^ 16'hBEEF, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One clock: models program_counter and imem, then settles 1ns past the edge.
  task automatic tick();
    logic [15:0] npc;
    logic [31:0] nd;
    npc = flush ? target : (pc_stall ? pc : pc + 16'd1);
    nd  = inst_of(pc);
    @(posedge clk);
    #1;
    pc        = npc;
    imem_data = nd;
  endtask

  initial begin
    reset = 1'b0; pc = '0; imem_data = '0; flush = 1'b0; pop = 2'd0; target = '0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_v0", 32'(out0_valid), 32'd0);
    chk("rst_stall", 32'(pc_stall), 32'd0);
    reset = 1'b1;

    // Fill without pops: count 0,0,1,2,3,4; stall from count=3 with a request in flight.
    tick(); chk("fill1_cnt", 32'(count), 32'd0); chk("fill1_stall", 32'(pc_stall), 32'd0);
    tick(); chk("fill2_cnt", 32'(count), 32'd1); chk("fill2_pc0", 32'(out0_pc), 32'd0);
    tick(); chk("fill3_cnt", 32'(count), 32'd2); chk("fill3_stall", 32'(pc_stall), 32'd0);
    tick(); chk("fill4_cnt", 32'(count), 32'd3); chk("fill4_stall", 32'(pc_stall), 32'd1);
    tick(); chk("fill5_cnt", 32'(count), 32'd4); chk("fill5_stall", 32'(pc_stall), 32'd1);
    chk("full_pc0", 32'(out0_pc), 32'd0);
    chk("full_pc1", 32'(out1_pc), 32'd1);
    chk("full_inst0", out0_inst, inst_of(16'd0));
    chk("full_inst1", out1_inst, inst_of(16'd1));
    chk("held_pc", 32'(pc), 32'd4);

    // Dual pop from full.
    pop = 2'd2; tick(); pop = 2'd0;
    chk("dpop_cnt", 32'(count), 32'd2);
    chk("dpop_pc0", 32'(out0_pc), 32'd2);
    chk("dpop_pc1", 32'(out1_pc), 32'd3);
    chk("dpop_stall", 32'(pc_stall), 32'd0);
    tick(); chk("cap4_pc", 32'(pc), 32'd5); chk("cap4_cnt", 32'(count), 32'd2);
    tick(); chk("refill_cnt", 32'(count), 32'd3); chk("refill_stall", 32'(pc_stall), 32'd1);
    tick(); chk("refull_cnt", 32'(count), 32'd4);

    // pop=3 behaves as pop=2.
    pop = 2'd3; tick(); pop = 2'd0;
    chk("pop3_cnt", 32'(count), 32'd2);
    chk("pop3_pc0", 32'(out0_pc), 32'd4);
    chk("pop3_pc1", 32'(out1_pc), 32'd5);
    chk("pop3_inst1", out1_inst, inst_of(16'd5));

    // Drain, then pop=2 against count=1 only removes one entry.
    pop = 2'd2; tick(); pop = 2'd0;
    chk("drain_cnt", 32'(count), 32'd0);
    chk("drain_v0", 32'(out0_valid), 32'd0);
    chk("drain_v1", 32'(out1_valid), 32'd0);
    tick(); chk("one_cnt", 32'(count), 32'd1); chk("one_pc0", 32'(out0_pc), 32'd6);
    pop = 2'd2; tick(); pop = 2'd0;
    chk("clamp_cnt", 32'(count), 32'd1);
    chk("clamp_pc0", 32'(out0_pc), 32'd7);
    chk("clamp_v1", 32'(out1_valid), 32'd0);

    // Flush with count=2 and a fetch in flight.
    tick(); chk("preflush_cnt", 32'(count), 32'd2);
    flush = 1'b1; target = 16'h0040; tick(); flush = 1'b0;
    chk("flush_cnt", 32'(count), 32'd0);
    chk("flush_stall", 32'(pc_stall), 32'd0);
    chk("flush_pc", 32'(pc), 32'h40);
    tick(); chk("flush2_v0", 32'(out0_valid), 32'd0);
    tick();
    chk("flush3_v0", 32'(out0_valid), 32'd1);
    chk("flush3_pc0", 32'(out0_pc), 32'h40);
    chk("flush3_inst0", out0_inst, inst_of(16'h40));
    chk("flush3_cnt", 32'(count), 32'd1);

    // Wrap-around stream: redirect to 0 and pop one per cycle.
    flush = 1'b1; target = 16'h0000; tick(); flush = 1'b0;
    tick(); tick();
    pop = 2'd1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("strm%0d_v0", i), 32'(out0_valid), 32'd1);
      chk($sformatf("strm%0d_pc", i), 32'(out0_pc), 32'(i));
      chk($sformatf("strm%0d_inst", i), out0_inst, inst_of(16'(i)));
      chk($sformatf("strm%0d_stall", i), 32'(pc_stall), 32'd0);
      tick();
    end
    pop = 2'd0;

    // Build count=3, then reset asynchronously between edges.
    begin
      int k;
      k = 0;
      while (count != 3'd3 && k < 8) begin tick(); k++; end
      chk("pre_rst_cnt", 32'(count), 32'd3);
    end
    #2 reset = 1'b0;
    #1;
    chk("arst_cnt", 32'(count), 32'd0);
    chk("arst_v0", 32'(out0_valid), 32'd0);
    chk("arst_v1", 32'(out1_valid), 32'd0);
    chk("arst_stall", 32'(pc_stall), 32'd0);
    pc = '0;
    #2 reset = 1'b1;
    tick(); chk("post_rst_cnt", 32'(count), 32'd0);
    tick();
    chk("post_rst_v0", 32'(out0_valid), 32'd1);
    chk("post_rst_pc0", 32'(out0_pc), 32'd0);
    chk("post_rst_inst0", out0_inst, inst_of(16'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between `program_counter` and decode. It captures each issued PC, pairs it with the 1-cycle-latency instruction-memory read data, and buffers {pc, instruction} pairs in a small circular FIFO. It presents the two oldest entries to a dual-issue decode stage. It back-pressures the PC through `pc_stall`, and it discards all buffered and in-flight fetches on a branch flush.

## Interface

- `ADDR_WIDTH`, 16, instruction-memory address width; matches the PC.
- `INST_WIDTH`, 32, instruction word width.
- `DEPTH`, 4, number of queue entries; must be a power of two and at least 2.

Ports:

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-low; the block is held in reset while 0.
- `pc`  in  ADDR_WIDTH  current PC from `program_counter`; also drives the instruction-memory address.
- `imem_data`  in  INST_WIDTH  instruction-memory read data for the address presented one cycle earlier.
- `flush`  in  1  branch mispredict or redirect; same signal that loads `branch_address` into the PC.
- `pop`  in  2  number of entries decode consumes this cycle (0, 1 or 2).
- `pc_stall`  out  1  stall to `program_counter`.
- `out0_valid`, `out0_pc`, `out0_inst`  out  1 / ADDR_WIDTH / INST_WIDTH  oldest entry.
- `out1_valid`, `out1_pc`, `out1_inst`  out  1 / ADDR_WIDTH / INST_WIDTH  second-oldest entry.
- `count`  out  clog2(DEPTH)+1  current occupancy.

## Operation

**State**
- Circular buffer of DEPTH {pc, inst} entries.
- `head` and `tail` pointers, each clog2(DEPTH) bits; both wrap modulo DEPTH.
- `count`.
- In-flight request register: `req_valid`, `req_pc`.

**Issue**
- When `pc_stall`=0 and `flush`=0: `req_valid`<=1 and `req_pc`<=`pc`.
- Otherwise `req_valid`<=0. A stalled PC holds its value and is re-issued once the stall clears.

**Push**
- When `req_valid`=1 and `flush`=0: write {`req_pc`, `imem_data`} at `tail`, then advance `tail`.

**Pop**
- `pop_eff` = min(`pop`, `count`, 2). A `pop` value of 3 is treated as 2.
- `head` advances by `pop_eff`.

**Count**
- `count`<=`count` + push − `pop_eff`.
- Push and pop in the same cycle are legal, including when the queue is full or empty.

**Stall**
- `pc_stall` = (`count` + `req_valid` >= DEPTH).
- It is decoded from registers only and deliberately ignores `pop`, so there is no combinational path from decode. This guarantees a push never meets a full queue.

**Flush**
- Highest priority after reset: `head`, `tail` and `count` go to 0, and `req_valid` goes to 0.
- The `imem_data` arriving that cycle is dropped.
- Any `pop` in that cycle is ignored.

**Outputs**
- `out0_*` shows the entry at `head`; `out1_*` shows the entry at `head`+1 (mod DEPTH).
- `out0_valid` = (`count` >= 1); `out1_valid` = (`count` >= 2).
- `outN_pc` and `outN_inst` are don't-care when the matching valid is 0, but must still be deterministic.

**Reset**
- `head`=0, `tail`=0, `count`=0, `req_valid`=0, `req_pc`=0.
- Therefore `pc_stall`=0, `out0_valid`=0 and `out1_valid`=0.
- Storage contents are not cleared.

## Timing

- Fetch latency is 2 cycles:
  - `pc` is captured at edge N.
  - `imem_data` for it is valid during cycle N+1 and pushed at edge N+1.
  - The entry is visible on `out0_*` during cycle N+2.
  - There is no bypass from `imem_data` to the outputs.
- Steady state with `pop`=1 every cycle: one instruction per cycle, and `pc_stall` stays 0.
- `pc_stall` rises in the cycle where `count` + `req_valid` reaches DEPTH. It falls the cycle after a pop brings `count` + `req_valid` back below DEPTH.
- Flush at edge F:
  - In cycle F+1, `pc` equals the branch target, `count` is 0 and `pc_stall` is 0, so the target is captured at edge F+1.
  - The first target entry appears on `out0` in cycle F+3.
- Asynchronous reset assertion mid-operation immediately forces `count`=0, `out*_valid`=0 and `pc_stall`=0, with no clock edge required. Issue resumes at the first edge after deassertion.

## Test plan

- **Reset:** assert `reset`=0 between edges with `count`=3 -> `out0_valid`, `out1_valid` and `pc_stall` drop to 0 before the next edge. After release, `pc`=0 is captured at the first edge.
- **Fill without pops** (DEPTH=4, PC increments 0,1,2,…):
  - Required: `count` reads 0,1,2,3,4 and `pc_stall`=1 from the cycle with `count`=3 and `req_valid`=1.
  - The queue ends holding pcs 0..3, and no entry is lost or duplicated.
- **Dual pop from full:** `pop`=2 with `count`=4 -> the next cycle shows `count`=2 and `out0_pc`=2, `out1_pc`=3. `pc_stall` clears one cycle later, and `pc`=4 is then captured.
- **Pop clamping:** `pop`=3 with `count`=4 -> treated as 2. `pop`=2 with `count`=1 and no push -> `count`=0 and `head` advances by 1 only.
- **Flush with in-flight fetch:** `flush`=1 while `count`=2, `req_valid`=1 and target 0x40 -> `count`=0 next cycle and the in-flight instruction is never pushed. `out0_pc`=0x40 with `out0_valid`=1 exactly 3 cycles after the flush edge.
- **Wrap-around:** stream 10 instructions with `pop`=1 per cycle -> `head` and `tail` wrap past DEPTH−1. Decode sees pcs 0..9 in order with matching `imem_data`.
